// File: rtl/or1k_spr_gpr_master.sv
// ---------------------------------------------------------------------------
// or1k_spr_gpr_master
//
// Debug-side SPR bus initiator for GPR access. It takes one read or write
// request at a time from the debug unit, waits until the core pipeline is
// stalled, and then strobes the GPR window of the SPR bus (group 0, offset
// 0x400). It returns read data or a write completion on the response channel.
// If no acknowledge arrives within TIMEOUT_CYCLES strobe cycles, it returns an
// error response instead.
//
// Valid/ready semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. Once the initiator raises valid, it
// keeps valid and its payload stable until that edge. Ready may be driven
// independently of valid.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   req_valid_i      request valid
//   req_ready_o      request ready (high only in IDLE)
//   req_we_i         1 = GPR write, 0 = GPR read
//   req_gpr_i        GPR index
//   req_dat_i        write data
//   rsp_valid_o      response valid
//   rsp_ready_i      response consumed
//   rsp_dat_o        read data; 0 for writes and errors
//   rsp_err_o        acknowledge timeout
//   cpu_stalled_i    core pipeline held; an access only starts while 1
//   spr_bus_addr_o   SPR address (0x0400 + GPR index)
//   spr_bus_stb_o    SPR strobe
//   spr_bus_we_o     SPR write enable
//   spr_bus_dat_o    SPR write data
//   spr_gpr_ack_i    GPR acknowledge
//   spr_gpr_dat_i    GPR read data, valid while ack is 1
//   fsm_state_o      current FSM state (debug visibility)
//
// OPTION_RF_ADDR_WIDTH must be 9 or less so the index fits below the
// 0x400 group/offset bits.
// ---------------------------------------------------------------------------
module or1k_spr_gpr_master #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] req_gpr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] req_dat_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_o,
  output logic                            rsp_err_o,
  input  logic                            cpu_stalled_i,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i,
  output logic [1:0]                      fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_STALL = 2'd1,
    ACCESS     = 2'd2,
    RESP       = 2'd3
  } state_t;

  localparam int          ADDR_PAD = 16 - OPTION_RF_ADDR_WIDTH;
  localparam logic [15:0] GPR_BASE = 16'h0400;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                          state_q;
  logic                            req_ready_q;
  logic                            rsp_valid_q;
  logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_q;
  logic                            rsp_err_q;
  logic [15:0]                     addr_q;
  logic                            stb_q;
  logic                            we_q;
  logic [OPTION_OPERAND_WIDTH-1:0] wdat_q;
  logic [7:0]                      cnt_q;
  logic [7:0]                      cnt_d;
  logic [15:0]                     addr_d;

  assign cnt_d  = cnt_q + 8'd1;
  assign addr_d = GPR_BASE | {{ADDR_PAD{1'b0}}, req_gpr_i};

  // The request's we/addr/data are latched directly into the bus output
  // registers at accept time. They stay put until the next request, so the
  // bus outputs also serve as the latched copy of the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      wdat_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            addr_q      <= addr_d;
            wdat_q      <= req_dat_i;
            cnt_q       <= '0;
            if (cpu_stalled_i) begin
              stb_q   <= 1'b1;
              state_q <= ACCESS;
            end else begin
              state_q <= WAIT_STALL;
            end
          end
        end

        // No timeout here: the debug unit may take any amount of time to
        // stall the core.
        WAIT_STALL: begin
          if (cpu_stalled_i) begin
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end

        // Once the strobe is up, it stays up until ack or timeout, even if
        // the stall is released. Dropping it mid-access could leave the
        // responder half way through.
        ACCESS: begin
          if (spr_gpr_ack_i) begin
            stb_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : spr_gpr_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            stb_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        // RESP plus the following IDLE cycle give at least two strobe-low
        // cycles between accesses. This lets the responder's registered
        // read-ack clear before the next strobe.
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign spr_bus_addr_o = addr_q;
  assign spr_bus_stb_o  = stb_q;
  assign spr_bus_we_o   = we_q;
  assign spr_bus_dat_o  = wdat_q;
  assign fsm_state_o    = state_q;

endmodule
